// File: rtl/lsm_seq_pkg.sv
// rtl/lsm_seq_pkg.sv - shared states, init table and WHO_AM_I constants for the LSM poll sequencer
package lsm_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_INIT_RELEASE,
    S_POLL_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RELEASE,
    S_PUBLISH,
    S_ERR
  } seq_state_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } init_entry_t;

  localparam int         INIT_LEN   = 2;
  localparam logic [7:0] WHOAMI_REG = 8'h0F;
  localparam logic [7:0] WHOAMI_VAL = 8'h6A;

  // CTRL1_XL then CTRL2_G, both 0x60
  function automatic init_entry_t init_entry(input logic [2:0] idx);
    init_entry_t e;
    case (idx)
      3'd0:    e = '{reg_addr: 8'h10, data: 8'h60};
      3'd1:    e = '{reg_addr: 8'h11, data: 8'h60};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsm_poll_sequencer_if.sv
// rtl/lsm_poll_sequencer_if.sv - byte-level I2C master request/response bundle
interface lsm_poll_sequencer_if;
  logic       i2c_en;
  logic       i2c_rw;
  logic [7:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_tx;
  logic [7:0] i2c_rx;
  logic       i2c_done;

  modport master (
    output i2c_en, i2c_rw, i2c_dev_addr, i2c_reg_addr, i2c_tx,
    input  i2c_rx, i2c_done
  );

  modport slave (
    input  i2c_en, i2c_rw, i2c_dev_addr, i2c_reg_addr, i2c_tx,
    output i2c_rx, i2c_done
  );
endinterface

// File: rtl/lsm_seq_timer.sv
// rtl/lsm_seq_timer.sv - loadable up-counter with clear and terminal-count flag
module lsm_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  // terminal count is compared before increment, so the counter never wraps
  assign tc = (cnt_q == term_val);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (load)       cnt_d = load_val;
    else if (inc && !tc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lsm_poll_sequencer.sv
// rtl/lsm_poll_sequencer.sv - LSM sensor init + periodic 6-byte poll; LSM_WHOAMI_CHECK_EN adds WHO_AM_I probe
module lsm_poll_sequencer
  import lsm_seq_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR  = 8'hD4,
  parameter logic [7:0]  FIRST_REG = 8'h22,
  parameter int          NBYTES    = 6,
  parameter logic [15:0] POLL_DIV  = 16'd50000,
  parameter logic [19:0] TIMEOUT   = 20'd200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  lsm_poll_sequencer_if.master  bus,
  output logic [8*NBYTES-1:0]   sample_data,
  output logic                  sample_valid,
  output logic                  init_done,
  output logic                  busy,
  output logic                  error
);
  seq_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       en_q, en_d, rw_q, rw_d;
  logic [7:0] dev_q, dev_d, reg_q, reg_d, tx_q, tx_d;
  logic [NBYTES-1:0][7:0] cap_q, cap_d;
  logic [8*NBYTES-1:0]    sdata_q, sdata_d;
  logic       svalid_q, svalid_d, init_done_q, init_done_d;
  logic       div_tc, to_tc, state_chg, in_wait;
  init_entry_t ent;
`ifdef LSM_WHOAMI_CHECK_EN
  logic       chk_q, chk_d;
`endif

  assign state_chg = (state_d != state_q);
  assign in_wait   = state_q inside {S_INIT_WAIT, S_INIT_RELEASE, S_RD_WAIT, S_RD_RELEASE};

  lsm_seq_timer #(.W(16)) u_div (
    .clk(clk), .rst_n(rst_n), .clr(state_chg), .inc(state_q == S_POLL_WAIT),
    .load(1'b0), .load_val(16'd0), .term_val(POLL_DIV - 16'd1), .tc(div_tc)
  );

  lsm_seq_timer #(.W(20)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(state_chg), .inc(in_wait),
    .load(1'b0), .load_val(20'd0), .term_val(TIMEOUT - 20'd1), .tc(to_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    tx_d        = tx_q;
    cap_d       = cap_q;
    sdata_d     = sdata_q;
    svalid_d    = 1'b0;
    init_done_d = init_done_q;
    ent         = init_entry(idx_q);
`ifdef LSM_WHOAMI_CHECK_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable && !init_done_q) begin
          idx_d = 3'd0;
`ifdef LSM_WHOAMI_CHECK_EN
          chk_d   = 1'b1;
          state_d = S_RD_ISSUE;
`else
          state_d = S_INIT_ISSUE;
`endif
        end else if (enable) begin
          state_d = S_POLL_WAIT;
        end
      end
      S_INIT_ISSUE: begin
        en_d    = 1'b1;
        rw_d    = 1'b1;
        dev_d   = DEV_ADDR;
        reg_d   = ent.reg_addr;
        tx_d    = ent.data;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (bus.i2c_done) begin
          en_d    = 1'b0;
          state_d = S_INIT_RELEASE;
        end else if (to_tc) begin
          en_d    = 1'b0;
          state_d = S_ERR;
        end
      end
      // a done held high for several cycles must be seen low before the next request
      S_INIT_RELEASE: begin
        if (!bus.i2c_done) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = S_POLL_WAIT;
          end else begin
            state_d = S_INIT_ISSUE;
          end
        end else if (to_tc) begin
          state_d = S_ERR;
        end
      end
      S_POLL_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (div_tc) begin
          idx_d   = 3'd0;
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        en_d    = 1'b1;
        rw_d    = 1'b0;
        dev_d   = DEV_ADDR;
        reg_d   = FIRST_REG + {5'd0, idx_q};
        tx_d    = 8'h00;
`ifdef LSM_WHOAMI_CHECK_EN
        if (chk_q) reg_d = WHOAMI_REG;
`endif
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.i2c_done) begin
          en_d = 1'b0;
          for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == 3'(k)) cap_d[k] = bus.i2c_rx;
          end
          state_d = S_RD_RELEASE;
        end else if (to_tc) begin
          en_d    = 1'b0;
          state_d = S_ERR;
        end
      end
      S_RD_RELEASE: begin
        if (!bus.i2c_done) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(NBYTES - 1)) state_d = S_PUBLISH;
          else                         state_d = S_RD_ISSUE;
`ifdef LSM_WHOAMI_CHECK_EN
          // the probe byte lands in capture slot 0, which the next full burst overwrites
          if (chk_q) begin
            chk_d   = 1'b0;
            idx_d   = 3'd0;
            state_d = (cap_q[0] == WHOAMI_VAL) ? S_INIT_ISSUE : S_ERR;
          end
`endif
        end else if (to_tc) begin
          state_d = S_ERR;
        end
      end
      S_PUBLISH: begin
        sdata_d  = cap_q;
        svalid_d = 1'b1;
        state_d  = S_POLL_WAIT;
      end
      S_ERR: begin
        en_d        = 1'b0;
        init_done_d = 1'b0;
`ifdef LSM_WHOAMI_CHECK_EN
        chk_d       = 1'b0;
`endif
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 8'h00;
      reg_q       <= 8'h00;
      tx_q        <= 8'h00;
      cap_q       <= '0;
      sdata_q     <= '0;
      svalid_q    <= 1'b0;
      init_done_q <= 1'b0;
`ifdef LSM_WHOAMI_CHECK_EN
      chk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      tx_q        <= tx_d;
      cap_q       <= cap_d;
      sdata_q     <= sdata_d;
      svalid_q    <= svalid_d;
      init_done_q <= init_done_d;
`ifdef LSM_WHOAMI_CHECK_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign bus.i2c_en       = en_q;
  assign bus.i2c_rw       = rw_q;
  assign bus.i2c_dev_addr = dev_q;
  assign bus.i2c_reg_addr = reg_q;
  assign bus.i2c_tx       = tx_q;
  assign sample_data      = sdata_q;
  assign sample_valid     = svalid_q;
  assign init_done        = init_done_q;
  assign busy  = state_q inside {S_INIT_ISSUE, S_INIT_WAIT, S_INIT_RELEASE,
                                 S_RD_ISSUE, S_RD_WAIT, S_RD_RELEASE};
  assign error = (state_q == S_ERR);
endmodule

// File: doc/lsm_poll_sequencer.md
Name: lsm_poll_sequencer

Overview:
- Sequences the byte-level I2C master for the LSM inertial sensor.
- After reset it runs a fixed register-write init table. It then periodically burst-reads 6 output bytes as single-byte transactions and publishes a 48-bit sample.
- Sits between the sensor-side logic and the I2C master. It is the only owner of the master's EN/RW/address/data inputs.

Parameters:
- DEV_ADDR, 8'hD4, device write address presented on i2c_dev_addr.
- FIRST_REG, 8'h22, register address of the first sample byte; byte k is read from FIRST_REG+k.
- NBYTES, 6, bytes per sample; fixed at 6 by the sample_data width.
- POLL_DIV, 16'd50000, idle clk cycles in POLL_WAIT between samples.
- TIMEOUT, 20'd200000, maximum clk cycles spent in any WAIT state before error.

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- enable, input, 1, level; high = run init (if needed) and poll
- i2c_en, output, 1, transaction request to the I2C master
- i2c_rw, output, 1, 1 = write i2c_tx to register, 0 = read register
- i2c_dev_addr, output, 8, device address to master
- i2c_reg_addr, output, 8, register address to master
- i2c_tx, output, 8, write data to master
- i2c_rx, input, 8, read data from master
- i2c_done, input, 1, master completion flag (may be held high several cycles)
- sample_data, output, 48, last published sample; byte k in bits [8k+7:8k]
- sample_valid, output, 1, one-cycle pulse when sample_data updates
- init_done, output, 1, high once the init table completes without error
- busy, output, 1, high while in any ISSUE/WAIT/RELEASE state
- error, output, 1, high in ERR

Behaviour:
- Reset: every output is 0, including i2c_dev_addr, sample_data and init_done. State is IDLE and all counters are 0.
- Clocking: a single clk domain. rst_n is asynchronous assert, synchronous deassert handled upstream.
- States: IDLE, INIT_ISSUE, INIT_WAIT, INIT_RELEASE, POLL_WAIT, RD_ISSUE, RD_WAIT, RD_RELEASE, PUBLISH, ERR.
- IDLE:
  - enable=1 and init_done=0 -> INIT_ISSUE with idx=0.
  - enable=1 and init_done=1 -> POLL_WAIT.
- ISSUE states (one cycle):
  - Drive i2c_dev_addr=DEV_ADDR, i2c_reg_addr, i2c_tx and i2c_rw. INIT uses rw=1 with the table entry; RD uses rw=0, reg=FIRST_REG+idx, i2c_tx=0.
  - Assert i2c_en and go to the matching WAIT.
- WAIT states:
  - Hold i2c_en=1 and all addr/data stable until i2c_done=1 is sampled.
  - On that cycle drop i2c_en and go to RELEASE. In RD_WAIT, also capture i2c_rx into byte idx.
- RELEASE states:
  - Wait for i2c_done=0 so that one held done is never counted twice.
  - Then idx+1. If more entries/bytes remain, go to the ISSUE state; otherwise INIT goes to POLL_WAIT with init_done<=1, and RD goes to PUBLISH.
- Timeout:
  - A single counter runs in every WAIT/RELEASE state and clears on each state entry.
  - Reaching TIMEOUT-1 -> ERR with i2c_en<=0.
- POLL_WAIT:
  - The divider counts 0..POLL_DIV-1, then goes to RD_ISSUE with idx=0.
  - enable=0 here -> IDLE, with the divider cleared.
- PUBLISH: update sample_data from the 6 capture bytes, pulse sample_valid for 1 cycle, then go to POLL_WAIT.
- enable dropping mid-transaction: the current transaction and burst run to completion. The exit to IDLE occurs only from POLL_WAIT. enable is not sampled in INIT states, so init always completes.
- ERR:
  - error=1, i2c_en=0, init_done<=0, sample_data retained.
  - enable=0 -> IDLE with error cleared. Re-enable then re-runs init.
- Partial burst aborted by ERR: nothing is published.
- Reset mid-operation: i2c_en drops immediately (async), and all state returns to reset values.
- Counter widths: 16-bit divider and 20-bit timeout. No wrap is possible because both are compared before increment.

Optional Feature:
- Macro: LSM_WHOAMI_CHECK_EN.
- With the macro defined: before the init table, one read of register 8'h0F is performed through the same ISSUE/WAIT/RELEASE states. If i2c_rx != 8'h6A, go to ERR. A match continues to the init table.
- Without the macro: the sequence starts directly at init table entry 0.

Decomposition:
- Package lsm_seq_pkg holds:
  - the state enum;
  - INIT_LEN=2;
  - the init table, {8'h10,8'h60} (CTRL1_XL) and {8'h11,8'h60} (CTRL2_G);
  - WHOAMI_REG=8'h0F and WHOAMI_VAL=8'h6A.
- One sub-module is natural: lsm_seq_timer, a loadable up-counter with clear and terminal-count flag. It is instantiated twice, for the divider and for the timeout.

Test Plan:
- Reset, enable=1, master model completing in 300 cycles -> writes (0x10,0x60) then (0x11,0x60), each with rw=1 and DEV_ADDR=0xD4; init_done rises after the second done.
- After init, rx model returns reg-0x22+k -> reads of 0x22..0x27 in order; sample_valid pulses once; sample_data=48'h050403020100.
- Master holds i2c_done high 5 cycles per transaction -> each transaction is counted exactly once and there are exactly 6 reads per sample.
- Master never asserts done, TIMEOUT=1000 -> error=1 within 1000 cycles of issue, i2c_en=0; enable=0 then 1 -> error clears and init re-runs.
- enable dropped during read byte 3 -> bytes 3..5 complete, sample_valid pulses, then IDLE; no further i2c_en.
- With LSM_WHOAMI_CHECK_EN and rx=0x69 for reg 0x0F -> ERR, with no init writes issued.
